// File: rtl/fft_pkg.sv
// Shared types and constants for the 16-point radix-2 DIF FFT core.
// beat_calc maps (stage, butterfly) to memory and twiddle addresses using shifts and masks.
package fft_pkg;

    localparam int N       = 16;
    localparam int LOG2N   = 4;
    localparam int TW_W    = 16;
    localparam int Q14_ONE = 16384;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic signed [TW_W-1:0] re;
        logic signed [TW_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic [3:0] addr_a;
        logic [3:0] addr_b;
        logic [2:0] tw_addr;
        logic [1:0] stage;
        logic       stage_last;
        logic       frame_last;
    } beat_t;

    // h = 8>>s, k = j & (h-1), g = j>>(3-s), addr_a = g<<(4-s) | k
    function automatic beat_t beat_calc(input logic [1:0] s, input logic [2:0] j);
        beat_t      b;
        logic [2:0] k;
        logic [2:0] g;
        logic [3:0] a;
        k            = j & (3'b111 >> s);
        g            = j >> (3'd3 - {1'b0, s});
        a            = ({1'b0, g} << (3'd4 - {1'b0, s})) | {1'b0, k};
        b.addr_a     = a;
        b.addr_b     = a + (4'd8 >> s);
        b.tw_addr    = k << s;
        b.stage      = s;
        b.stage_last = (j == 3'd7);
        b.frame_last = (j == 3'd7) && (s == 2'd3);
        return b;
    endfunction

endpackage

// File: rtl/w_lut.sv
// Registered 8-entry twiddle ROM, W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16) in Q1.14.
// conj_i negates the imaginary part before the register for inverse transforms.
module w_lut
    import fft_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [2:0] addr_i,
    input  logic       conj_i,
    output cplx_t      tw_o
);

    cplx_t base;
    cplx_t tw_d;
    cplx_t tw_q;

    always_comb begin
        base = '0;
        case (addr_i)
            3'd0: base = {16'sd16384, 16'sd0};
            3'd1: base = {16'sd15137, -16'sd6270};
            3'd2: base = {16'sd11585, -16'sd11585};
            3'd3: base = {16'sd6270, -16'sd15137};
            3'd4: base = {16'sd0, -16'sd16384};
            3'd5: base = {-16'sd6270, -16'sd15137};
            3'd6: base = {-16'sd11585, -16'sd11585};
            3'd7: base = {-16'sd15137, -16'sd6270};
            default: base = '0;
        endcase
    end

    // |im| <= 16384, so the negation cannot overflow
    always_comb begin
        tw_d = base;
        if (conj_i) begin
            tw_d.im = -base.im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tw_q <= '0;
        end else if (clr_i) begin
            tw_q <= '0;
        end else if (en_i) begin
            tw_q <= tw_d;
        end
    end

    assign tw_o = tw_q;

endmodule

// File: rtl/fft_tw_seq.sv
// Butterfly/twiddle sequencer: walks 4 stages x 8 butterflies per frame and presents
// one registered beat per handshake. A beat is valid when out_valid is high and transfers on out_valid & out_ready.
module fft_tw_seq
    import fft_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        inv,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  addr_a,
    output logic [3:0]  addr_b,
    output logic [2:0]  tw_addr,
    output logic [31:0] tw,
    output logic [1:0]  stage,
    output logic        stage_last,
    output logic        frame_last,
    output state_e      dbg_state
);

    state_e     state_q, state_d;
    logic [1:0] s_q, s_d;
    logic [2:0] j_q, j_d;
    logic       inv_q, inv_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    beat_t      beat_q, beat_d;
    beat_t      beat_nxt;
    logic       load;
    logic       clr;
    cplx_t      tw_val;

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        j_d      = j_q;
        inv_d    = inv_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load     = 1'b0;
        clr      = 1'b0;
        beat_nxt = '0;
        beat_d   = beat_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    inv_d   = inv;
                    s_d     = 2'd0;
                    j_d     = 3'd0;
                    load    = 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (valid_q && out_ready) begin
                    if (beat_q.frame_last) begin
                        s_d     = 2'd0;
                        j_d     = 3'd0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        j_d  = j_q + 3'd1;
                        s_d  = (j_q == 3'd7) ? s_q + 2'd1 : s_q;
                        load = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // abort overrides any start or handshake in the same cycle
        if (abort) begin
            state_d = ST_IDLE;
            s_d     = 2'd0;
            j_d     = 3'd0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            load    = 1'b0;
            clr     = 1'b1;
        end

        beat_nxt = beat_calc(s_d, j_d);
        if (clr) begin
            beat_d = '0;
        end else if (load) begin
            beat_d = beat_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= 2'd0;
            j_q     <= 3'd0;
            inv_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            inv_q   <= inv_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            beat_q  <= beat_d;
        end
    end

    // LUT is addressed with the next beat so tw registers alongside beat_q
    w_lut u_w_lut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .en_i   (load),
        .addr_i (beat_nxt.tw_addr),
        .conj_i (inv_d),
        .tw_o   (tw_val)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign out_valid  = valid_q;
    assign addr_a     = beat_q.addr_a;
    assign addr_b     = beat_q.addr_b;
    assign tw_addr    = beat_q.tw_addr;
    assign tw         = tw_val;
    assign stage      = beat_q.stage;
    assign stage_last = beat_q.stage_last;
    assign frame_last = beat_q.frame_last;
    assign dbg_state  = state_q;

endmodule
